// File: rtl/cnn_div_pkg.sv
// Shared widths, saturation limits and FSM state encoding for the CNN signed divider.
package cnn_div_pkg;
    localparam int DIVIDEND_W = 24;
    localparam int DIVISOR_W  = 9;
    localparam int QUOT_W     = 14;
    localparam int PR_W       = DIVISOR_W + 1;
    localparam int CNT_W      = $clog2(DIVIDEND_W);
    localparam int QMAX       = 8191;
    localparam int QMIN       = -8192;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/cnn_sdiv_step.sv
// One restoring-division iteration on unsigned magnitudes.
module cnn_sdiv_step
    import cnn_div_pkg::*;
(
    input  logic [PR_W-1:0] pr_i,
    input  logic            bit_i,
    input  logic [PR_W-1:0] dvs_i,
    output logic [PR_W-1:0] pr_o,
    output logic            q_o
);
    logic [PR_W:0] sh, diff;
    logic          unused_diff;

    assign sh          = {pr_i, bit_i};
    assign diff        = sh - {1'b0, dvs_i};
    assign q_o         = (sh >= {1'b0, dvs_i});
    assign pr_o        = q_o ? diff[PR_W-1:0] : sh[PR_W-1:0];
    assign unused_diff = diff[PR_W];
endmodule

// File: rtl/cnn_sdiv_24s_9s_14_seq.sv
// Iterative 24s / 9s signed divider: 24 restoring steps, sign fix-up, saturation to 14s.
module cnn_sdiv_24s_9s_14_seq
    import cnn_div_pkg::*;
(
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_start,
    output logic                         ap_ready,
    output logic                         ap_idle,
    output logic                         ap_done,
    input  logic [DIVIDEND_W-1:0]        din0,
    input  logic [DIVISOR_W-1:0]         din1,
    output logic signed [QUOT_W-1:0]     dout,
    output logic signed [DIVISOR_W-1:0]  rem,
    output logic                         ovf,
    output logic                         dz
);
    state_t                     state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [DIVIDEND_W-1:0]      dvd_q;
    logic [PR_W-1:0]            dvs_q, pr_q, pr_n;
    logic                       s0_q, s1_q, zdiv_q, qb;
    logic signed [QUOT_W-1:0]   dout_q, dout_d;
    logic [DIVISOR_W-1:0]       rem_q, rem_d, rmag;
    logic                       ovf_q, ovf_d, dz_q;
    logic [DIVIDEND_W-1:0]      mag0;
    logic [DIVISOR_W-1:0]       mag1;
    logic                       neg, unused_pr;

    // |-2^23| and |-256| both fit their unsigned magnitude fields
    assign mag0 = din0[DIVIDEND_W-1] ? (~din0 + 1'b1) : din0;
    assign mag1 = din1[DIVISOR_W-1]  ? (~din1 + 1'b1) : din1;

    cnn_sdiv_step u_step (
        .pr_i  (pr_q),
        .bit_i (dvd_q[DIVIDEND_W-1]),
        .dvs_i (dvs_q),
        .pr_o  (pr_n),
        .q_o   (qb)
    );

    assign rmag      = pr_q[DIVISOR_W-1:0];
    assign unused_pr = pr_q[PR_W-1];
    assign neg       = (s0_q ^ s1_q) && (dvd_q != '0);

    always_comb begin
        dout_d = QUOT_W'(QMAX);
        rem_d  = '0;
        ovf_d  = 1'b0;
        if (zdiv_q) begin
            dout_d = s0_q ? QUOT_W'(QMIN) : QUOT_W'(QMAX);
        end else begin
            rem_d = s0_q ? (~rmag + 1'b1) : rmag;
            if (neg) begin
                if (dvd_q > DIVIDEND_W'(-QMIN)) begin
                    dout_d = QUOT_W'(QMIN);
                    ovf_d  = 1'b1;
                end else begin
                    dout_d = ~dvd_q[QUOT_W-1:0] + 1'b1;
                end
            end else if (dvd_q > DIVIDEND_W'(QMAX)) begin
                ovf_d = 1'b1;
            end else begin
                dout_d = dvd_q[QUOT_W-1:0];
            end
        end
    end

    // dvd_q starts as |dividend| and fills with quotient bits from the LSB
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            zdiv_q  <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ap_start) begin
                    state_q <= CALC;
                    cnt_q   <= CNT_W'(DIVIDEND_W - 1);
                    dvd_q   <= mag0;
                    dvs_q   <= {1'b0, mag1};
                    pr_q    <= '0;
                    s0_q    <= din0[DIVIDEND_W-1];
                    s1_q    <= din1[DIVISOR_W-1];
                    zdiv_q  <= (din1 == '0);
                end
                CALC: begin
                    dvd_q <= {dvd_q[DIVIDEND_W-2:0], qb};
                    pr_q  <= pr_n;
                    if (cnt_q == '0) state_q <= FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                FIX: begin
                    dout_q  <= dout_d;
                    rem_q   <= rem_d;
                    ovf_q   <= ovf_d;
                    dz_q    <= zdiv_q;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ap_idle  = (state_q == IDLE);
    assign ap_ready = ap_idle & ap_start;
    assign ap_done  = (state_q == DONE);
    assign dout     = dout_q;
    assign rem      = rem_q;
    assign ovf      = ovf_q;
    assign dz       = dz_q;
endmodule

// File: tb/tb_cnn_sdiv_24s_9s_14_seq.sv
// Bench for the iterative signed divider: vector table, reset abort, back-to-back requests.
module tb_cnn_sdiv_24s_9s_14_seq;
    logic        ap_clk = 1'b0, ap_rst_n = 1'b0, ap_start = 1'b0;
    logic        ap_ready, ap_idle, ap_done, ovf, dz;
    logic [23:0] din0 = '0;
    logic [8:0]  din1 = '0;
    logic signed [13:0] dout;
    logic signed [8:0]  rem;

    int checks = 0, failures = 0, cyc = 0;

    typedef struct { int a; int b; int q; int r; int o; int z; } vec_t;
    typedef struct { int q; int r; int o; int z; int acc; } exp_t;
    exp_t sb[$];
    vec_t vt[$];

    cnn_sdiv_24s_9s_14_seq dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_done(ap_done),
        .din0(din0), .din1(din1), .dout(dout), .rem(rem), .ovf(ovf), .dz(dz)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        e.acc = 0; e.o = 0; e.z = 0;
        if (b == 0) begin
            e.q = (a >= 0) ? 8191 : -8192; e.r = 0; e.z = 1;
        end else begin
            e.q = a / b; e.r = a % b;
            if (e.q > 8191)       begin e.q = 8191;  e.o = 1; end
            else if (e.q < -8192) begin e.q = -8192; e.o = 1; end
        end
        return e;
    endfunction

    // Result monitor: pops the scoreboard on each ap_done
    always @(negedge ap_clk) begin
        if (ap_rst_n && ap_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dout", int'(dout), e.q);
                chk("rem", int'(rem), e.r);
                chk("ovf", int'(ovf), e.o);
                chk("dz", int'(dz), e.z);
                chk("latency", cyc - e.acc, 26);
                chk("idle_in_done", int'(ap_idle), 0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!ap_idle && n < 100) begin @(negedge ap_clk); n++; end
        if (!ap_idle) chk("idle_timeout", 0, 1);
    endtask

    task automatic start_op(input int a, input int b, input exp_t e);
        wait_idle();
        @(negedge ap_clk);
        ap_start = 1'b1; din0 = a[23:0]; din1 = b[8:0];
        #1;
        chk("ready", int'(ap_ready), 1);
        e.acc = cyc;
        sb.push_back(e);
        @(negedge ap_clk);
        ap_start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge ap_clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.q = v.q; e.r = v.r; e.o = v.o; e.z = v.z; e.acc = 0;
        return e;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt.push_back('{1000, 7, 142, 6, 0, 0});
        vt.push_back('{-1000, 7, -142, -6, 0, 0});
        vt.push_back('{1000, -7, -142, 6, 0, 0});
        vt.push_back('{-6, 7, 0, -6, 0, 0});
        vt.push_back('{8388607, 1, 8191, 0, 1, 0});
        vt.push_back('{-8388608, -1, 8191, 0, 1, 0});
        vt.push_back('{-8388608, 1, -8192, 0, 1, 0});
        vt.push_back('{500, 0, 8191, 0, 0, 1});
        vt.push_back('{-500, 0, -8192, 0, 0, 1});
        vt.push_back('{12345, -256, -48, 57, 0, 0});
        vt.push_back('{8191, 1, 8191, 0, 0, 0});
        vt.push_back('{8192, 1, 8191, 0, 1, 0});
        vt.push_back('{-8192, 1, -8192, 0, 0, 0});
        vt.push_back('{-8193, 1, -8192, 0, 1, 0});
        vt.push_back('{-8388608, -256, 8191, 0, 1, 0});
        vt.push_back('{255, -256, 0, 255, 0, 0});
        vt.push_back('{-255, 256 - 512, 0, -255, 0, 0});
        vt.push_back('{0, -5, 0, 0, 0, 0});

        repeat (3) @(negedge ap_clk);
        chk("rst_idle", int'(ap_idle), 1);
        chk("rst_ready", int'(ap_ready), 0);
        chk("rst_done", int'(ap_done), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_rem", int'(rem), 0);
        chk("rst_flags", int'({ovf, dz}), 0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        foreach (vt[i]) begin
            start_op(vt[i].a, vt[i].b, to_exp(vt[i]));
            drain();
            @(negedge ap_clk);
            chk("hold_dout", int'(dout), vt[i].q);
        end

        // start pulse during CALC must be ignored
        start_op(1000, 7, model(1000, 7));
        repeat (5) @(negedge ap_clk);
        ap_start = 1'b1; din0 = 24'd5; din1 = 9'd1;
        #1 chk("ready_in_calc", int'(ap_ready), 0);
        @(negedge ap_clk);
        ap_start = 1'b0;
        drain();

        // asynchronous abort at T+10
        start_op(1000, 7, model(1000, 7));
        repeat (9) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_idle", int'(ap_idle), 1);
        chk("abort_dout", int'(dout), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (30) @(negedge ap_clk);
        start_op(1000, 7, model(1000, 7));
        drain();

        // continuous ap_start with changing operands
        wait_idle();
        for (int k = 0; k < 108; k++) begin
            logic [19:0] r;
            @(negedge ap_clk);
            r = 20'($urandom);
            din0 = {{4{r[19]}}, r};
            din1 = 9'($urandom);
            ap_start = 1'b1;
            #1;
            chk("cont_ready", int'(ap_ready), int'(k % 27 == 0));
            if (ap_ready) begin
                exp_t e;
                e = model(int'($signed(din0)), int'($signed(din1)));
                e.acc = cyc;
                sb.push_back(e);
            end
        end
        @(negedge ap_clk);
        ap_start = 1'b0;
        drain();
        repeat (3) @(negedge ap_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
